// File: rtl/dcache_ctrl.sv
//-----------------------------------------------------------------------------
// dcache_ctrl
//
// Data cache controller for the MEM stage: direct-mapped, one 32-bit word per
// line, write-through, no-write-allocate.
//
//   * Load hit   : data returned combinationally, no stall.
//   * Load miss  : stall, read the word from memory, fill the line and return
//                  the word in the cycle the memory completes.
//   * Store      : always written through to memory (stall until mem_ready);
//                  on completion a hitting line is byte-merged, a missing
//                  line is left alone (no allocation).
//
// The core holds all i_core_* inputs stable while o_cache_stall is high, so
// the index/tag/hit of the pending access can be recomputed from the live
// inputs in every state and need not be captured.
//
// Parameter
//   INDEX_BITS      line-index width (2**INDEX_BITS lines, tag = 30-INDEX_BITS)
//
// Optional build macro
//   DCACHE_PERF_EN  adds o_hit_count / o_miss_count event counters
//
// Ports
//   i_clk, i_rst          clock, synchronous active-high reset
//   i_core_req            MEM-stage access valid
//   i_core_write          1 = store, 0 = load
//   i_core_addr[31:0]     byte address (bits [1:0] ignored)
//   i_core_wdata[31:0]    store data
//   i_core_wstrb[3:0]     store byte enables
//   o_core_rdata[31:0]    load data (0 unless hit / fill-completion cycle)
//   o_cache_stall         pipeline freeze request
//   o_mem_req             memory transaction valid      (registered)
//   o_mem_write           memory transaction type       (registered)
//   o_mem_addr[31:0]      word-aligned address          (registered)
//   o_mem_wdata[31:0]     write data                    (registered)
//   o_mem_wstrb[3:0]      write strobes                 (registered)
//   i_mem_ready           memory completes this cycle
//   i_mem_rdata[31:0]     read data, valid with i_mem_ready
//   o_hit_count[31:0]     (DCACHE_PERF_EN) IDLE load-hit cycles
//   o_miss_count[31:0]    (DCACHE_PERF_EN) load-miss detections
//-----------------------------------------------------------------------------
module dcache_ctrl #(
  parameter int INDEX_BITS = 6
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_core_req,
  input  logic        i_core_write,
  input  logic [31:0] i_core_addr,
  input  logic [31:0] i_core_wdata,
  input  logic [3:0]  i_core_wstrb,
  output logic [31:0] o_core_rdata,
  output logic        o_cache_stall,
  output logic        o_mem_req,
  output logic        o_mem_write,
  output logic [31:0] o_mem_addr,
  output logic [31:0] o_mem_wdata,
  output logic [3:0]  o_mem_wstrb,
  input  logic        i_mem_ready,
  input  logic [31:0] i_mem_rdata
`ifdef DCACHE_PERF_EN
  ,
  output logic [31:0] o_hit_count,
  output logic [31:0] o_miss_count
`endif
);

  localparam int LINES = 2 ** INDEX_BITS;
  localparam int TAG_W = 30 - INDEX_BITS;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RMISS = 2'd1,
    S_WRITE = 2'd2
  } state_t;

  // Replace the strobe-selected bytes of a stored word with new store data.
  function automatic logic [31:0] f_merge_bytes(
    input logic [31:0] old_word,
    input logic [31:0] new_word,
    input logic [3:0]  strb
  );
    logic [31:0] res;
    res = old_word;
    for (int b = 0; b < 4; b++) begin
      res[8*b +: 8] = strb[b] ? new_word[8*b +: 8] : old_word[8*b +: 8];
    end
    return res;
  endfunction

  // Cache storage. Only the valid bits are reset; tag/data are qualified by valid.
  logic [LINES-1:0] r_valid;
  logic [TAG_W-1:0] r_tag  [LINES];
  logic [31:0]      r_data [LINES];

  state_t r_state;
  state_t w_state_nxt;

  logic        r_mem_req;
  logic        r_mem_write;
  logic [31:0] r_mem_addr;
  logic [31:0] r_mem_wdata;
  logic [3:0]  r_mem_wstrb;

  logic [INDEX_BITS-1:0] w_idx;
  logic [TAG_W-1:0]      w_tag;
  logic                  w_hit;
  logic                  w_issue;   // launch a memory transaction at the next edge
  logic                  w_fill;    // write a fetched word into the line
  logic                  w_merge;   // byte-merge store data into a hitting line
  logic                  w_done;    // memory transaction completes this cycle
  logic                  w_unused_addr_bits;

  assign w_idx = i_core_addr[INDEX_BITS+1:2];
  assign w_tag = i_core_addr[31:INDEX_BITS+2];
  assign w_hit = r_valid[w_idx] && (r_tag[w_idx] == w_tag);

  // Byte offset inside the word plays no role in a word-granular cache.
  assign w_unused_addr_bits = ^i_core_addr[1:0];

  // Next-state, stall, load-data and storage-update decode.
  always_comb begin
    w_state_nxt   = r_state;
    o_cache_stall = 1'b0;
    o_core_rdata  = 32'h0000_0000;
    w_issue       = 1'b0;
    w_fill        = 1'b0;
    w_merge       = 1'b0;
    w_done        = 1'b0;
    if (i_rst) begin
      // Reset overrides everything: no stall, no data, nothing written.
      w_state_nxt = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (i_core_req) begin
            if (i_core_write) begin
              // Write-through: every store goes to memory, hit or miss.
              o_cache_stall = 1'b1;
              w_issue       = 1'b1;
              w_state_nxt   = S_WRITE;
            end else if (w_hit) begin
              o_core_rdata  = r_data[w_idx];
            end else begin
              o_cache_stall = 1'b1;
              w_issue       = 1'b1;
              w_state_nxt   = S_RMISS;
            end
          end else begin
            w_state_nxt = S_IDLE;
          end
        end
        S_RMISS: begin
          if (i_mem_ready) begin
            // Forward the fetched word straight to the core while filling.
            w_fill       = 1'b1;
            w_done       = 1'b1;
            o_core_rdata = i_mem_rdata;
            w_state_nxt  = S_IDLE;
          end else begin
            o_cache_stall = 1'b1;
          end
        end
        S_WRITE: begin
          if (i_mem_ready) begin
            // Only an already-present line is updated; misses do not allocate.
            w_merge     = w_hit;
            w_done      = 1'b1;
            w_state_nxt = S_IDLE;
          end else begin
            o_cache_stall = 1'b1;
          end
        end
        default: begin
          w_state_nxt = S_IDLE;
        end
      endcase
    end
  end

  // Controller state register.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Memory request registers: loaded on launch, held until completion.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_mem_req   <= 1'b0;
      r_mem_write <= 1'b0;
      r_mem_addr  <= 32'h0000_0000;
      r_mem_wdata <= 32'h0000_0000;
      r_mem_wstrb <= 4'b0000;
    end else if (w_issue) begin
      r_mem_req   <= 1'b1;
      r_mem_write <= i_core_write;
      r_mem_addr  <= {i_core_addr[31:2], 2'b00};
      r_mem_wdata <= i_core_write ? i_core_wdata : 32'h0000_0000;
      r_mem_wstrb <= i_core_write ? i_core_wstrb : 4'b0000;
    end else if (w_done) begin
      r_mem_req   <= 1'b0;
    end
  end

  // Line valid bits: cleared by reset, set by a completed fill.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_valid <= {LINES{1'b0}};
    end else if (w_fill) begin
      r_valid[w_idx] <= 1'b1;
    end
  end

  // Tag and data arrays (unreset); fill and store-merge are mutually exclusive.
  always_ff @(posedge i_clk) begin
    if (w_fill) begin
      r_tag[w_idx]  <= w_tag;
      r_data[w_idx] <= i_mem_rdata;
    end else if (w_merge) begin
      r_data[w_idx] <= f_merge_bytes(r_data[w_idx], i_core_wdata, i_core_wstrb);
    end
  end

  assign o_mem_req   = r_mem_req;
  assign o_mem_write = r_mem_write;
  assign o_mem_addr  = r_mem_addr;
  assign o_mem_wdata = r_mem_wdata;
  assign o_mem_wstrb = r_mem_wstrb;

`ifdef DCACHE_PERF_EN
  logic        w_load_hit;
  logic        w_load_miss;
  logic [31:0] r_hit_count;
  logic [31:0] r_miss_count;

  assign w_load_hit  = !i_rst && (r_state == S_IDLE) && i_core_req && !i_core_write && w_hit;
  assign w_load_miss = w_issue && !i_core_write;

  // Load hit / miss event counters (stores are not counted; wrap naturally).
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_hit_count  <= 32'd0;
      r_miss_count <= 32'd0;
    end else begin
      if (w_load_hit) begin
        r_hit_count <= r_hit_count + 32'd1;
      end
      if (w_load_miss) begin
        r_miss_count <= r_miss_count + 32'd1;
      end
    end
  end

  assign o_hit_count  = r_hit_count;
  assign o_miss_count = r_miss_count;
`endif

endmodule

// File: tb/tb_dcache_ctrl.sv
//-----------------------------------------------------------------------------
// tb_dcache_ctrl
//
// Directed bench for dcache_ctrl. The bench plays the memory and keeps a
// line-level model of the cache (which word address each index holds, and
// its value). Driver tasks compute, per cycle, what stall / load data / memory
// request must look like from that model; one compare process checks the DUT
// on every falling edge. A few literal expectations pin the model.
//-----------------------------------------------------------------------------
module tb_dcache_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        core_req;
  logic        core_write;
  logic [31:0] core_addr;
  logic [31:0] core_wdata;
  logic [3:0]  core_wstrb;
  logic [31:0] core_rdata;
  logic        cache_stall;
  logic        mem_req;
  logic        mem_write;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        mem_ready;
  logic [31:0] mem_rdata;
`ifdef DCACHE_PERF_EN
  logic [31:0] hit_count;
  logic [31:0] miss_count;
`endif

  always #5 clk = ~clk;

  dcache_ctrl dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_core_req   (core_req),
    .i_core_write (core_write),
    .i_core_addr  (core_addr),
    .i_core_wdata (core_wdata),
    .i_core_wstrb (core_wstrb),
    .o_core_rdata (core_rdata),
    .o_cache_stall(cache_stall),
    .o_mem_req    (mem_req),
    .o_mem_write  (mem_write),
    .o_mem_addr   (mem_addr),
    .o_mem_wdata  (mem_wdata),
    .o_mem_wstrb  (mem_wstrb),
    .i_mem_ready  (mem_ready),
    .i_mem_rdata  (mem_rdata)
`ifdef DCACHE_PERF_EN
    ,
    .o_hit_count  (hit_count),
    .o_miss_count (miss_count)
`endif
  );

  // Line-level model: 64 lines, each holding one word address and its value.
  bit          m_valid [64];
  logic [29:0] m_waddr [64];
  logic [31:0] m_data  [64];
  logic [31:0] m_hits;
  logic [31:0] m_misses;
  int          pend_hits;
  int          pend_misses;

  // Per-cycle expectations.
  bit          chk_en;
  logic        exp_stall;
  logic [31:0] exp_rdata;
  logic        exp_mem_req;
  logic        exp_mem_write;
  logic [31:0] exp_mem_addr;
  logic [31:0] exp_mem_wdata;
  logic [3:0]  exp_mem_wstrb;
  bit          exp_chk_wd;

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Per-cycle compare against the model's expectations.
  always @(negedge clk) begin
    if (chk_en) begin
      check("cache_stall", 32'(cache_stall), 32'(exp_stall));
      check("core_rdata", core_rdata, exp_rdata);
      check("mem_req", 32'(mem_req), 32'(exp_mem_req));
      if (exp_mem_req) begin
        check("mem_write", 32'(mem_write), 32'(exp_mem_write));
        check("mem_addr", mem_addr, exp_mem_addr);
        if (exp_chk_wd) begin
          check("mem_wdata", mem_wdata, exp_mem_wdata);
          check("mem_wstrb", 32'(mem_wstrb), 32'(exp_mem_wstrb));
        end
      end
`ifdef DCACHE_PERF_EN
      check("hit_count", hit_count, m_hits);
      check("miss_count", miss_count, m_misses);
`endif
    end
  end

  function automatic bit model_hit(input logic [31:0] addr);
    return m_valid[addr[7:2]] && (m_waddr[addr[7:2]] == addr[31:2]);
  endfunction

  // Advance one clock; apply reset / counter events that the edge committed.
  task automatic next_cycle();
    @(posedge clk);
    if (rst) begin
      for (int i = 0; i < 64; i++) m_valid[i] = 1'b0;
      m_hits   = 32'd0;
      m_misses = 32'd0;
    end else begin
      m_hits   = m_hits + 32'(pend_hits);
      m_misses = m_misses + 32'(pend_misses);
    end
    pend_hits   = 0;
    pend_misses = 0;
    #1;
  endtask

  task automatic set_idle_exp();
    exp_stall   = 1'b0;
    exp_rdata   = 32'h0;
    exp_mem_req = 1'b0;
    exp_chk_wd  = 1'b0;
  endtask

  task automatic do_idle(input int n, input logic ready);
    for (int i = 0; i < n; i++) begin
      next_cycle();
      core_req   = 1'b0;
      core_write = $urandom_range(0, 1) != 0;
      core_addr  = $urandom;
      mem_ready  = ready;
      mem_rdata  = $urandom;
      set_idle_exp();
      @(negedge clk);
    end
  endtask

  task automatic do_load(input logic [31:0] addr, input int waits, input logic [31:0] fill,
                         output bit was_hit, output logic [31:0] got);
    logic [5:0] idx;
    idx     = addr[7:2];
    was_hit = model_hit(addr);
    next_cycle();
    core_req   = 1'b1;
    core_write = 1'b0;
    core_addr  = addr;
    core_wdata = $urandom;
    core_wstrb = 4'hF;
    mem_rdata  = $urandom;
    exp_mem_req = 1'b0;
    exp_chk_wd  = 1'b0;
    if (was_hit) begin
      mem_ready = 1'b1;              // stray ready while idle must be ignored
      exp_stall = 1'b0;
      exp_rdata = m_data[idx];
      pend_hits++;
      @(negedge clk);
      got = core_rdata;
    end else begin
      mem_ready = 1'b0;
      exp_stall = 1'b1;
      exp_rdata = 32'h0;
      pend_misses++;
      @(negedge clk);
      for (int w = 0; w <= waits; w++) begin
        next_cycle();
        exp_mem_req   = 1'b1;
        exp_mem_write = 1'b0;
        exp_mem_addr  = {addr[31:2], 2'b00};
        if (w == waits) begin
          mem_ready = 1'b1;
          mem_rdata = fill;
          exp_stall = 1'b0;
          exp_rdata = fill;
        end else begin
          mem_ready = 1'b0;
          mem_rdata = $urandom;
          exp_stall = 1'b1;
          exp_rdata = 32'h0;
        end
        @(negedge clk);
      end
      got = core_rdata;
      m_valid[idx] = 1'b1;
      m_waddr[idx] = addr[31:2];
      m_data[idx]  = fill;
    end
  endtask

  task automatic do_store(input logic [31:0] addr, input logic [31:0] wd,
                          input logic [3:0] strb, input int waits);
    logic [5:0] idx;
    bit         hit;
    idx = addr[7:2];
    hit = model_hit(addr);
    next_cycle();
    core_req   = 1'b1;
    core_write = 1'b1;
    core_addr  = addr;
    core_wdata = wd;
    core_wstrb = strb;
    mem_ready  = 1'b0;
    mem_rdata  = $urandom;
    exp_stall   = 1'b1;
    exp_rdata   = 32'h0;
    exp_mem_req = 1'b0;
    exp_chk_wd  = 1'b0;
    @(negedge clk);
    for (int w = 0; w <= waits; w++) begin
      next_cycle();
      exp_mem_req   = 1'b1;
      exp_mem_write = 1'b1;
      exp_mem_addr  = {addr[31:2], 2'b00};
      exp_chk_wd    = 1'b1;
      exp_mem_wdata = wd;
      exp_mem_wstrb = strb;
      exp_rdata     = 32'h0;
      mem_ready     = (w == waits);
      mem_rdata     = $urandom;
      exp_stall     = (w != waits);
      @(negedge clk);
    end
    if (hit) begin
      for (int b = 0; b < 4; b++) begin
        if (strb[b]) m_data[idx][8*b +: 8] = wd[8*b +: 8];
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bit          h;
    logic [31:0] d;
`ifdef DCACHE_PERF_EN
    logic [31:0] h0;
    logic [31:0] m0;
`endif
    rst        = 1'b1;
    core_req   = 1'b0;
    core_write = 1'b0;
    core_addr  = 32'h0;
    core_wdata = 32'h0;
    core_wstrb = 4'h0;
    mem_ready  = 1'b0;
    mem_rdata  = 32'h0;
    chk_en     = 1'b0;
    for (int i = 0; i < 64; i++) m_valid[i] = 1'b0;
    m_hits      = 32'd0;
    m_misses    = 32'd0;
    pend_hits   = 0;
    pend_misses = 0;
    set_idle_exp();

    // Reset state.
    @(posedge clk);
    #1;
    chk_en = 1'b1;
    @(negedge clk);
    check("rst_mem_write", 32'(mem_write), 32'h0);
    check("rst_mem_addr", mem_addr, 32'h0);
    check("rst_mem_wdata", mem_wdata, 32'h0);
    check("rst_mem_wstrb", 32'(mem_wstrb), 32'h0);
    next_cycle();
    rst = 1'b0;
    set_idle_exp();
    @(negedge clk);

    // mem_ready with no request outstanding is ignored.
    do_idle(2, 1'b1);

    // Cold load, ready on the 2nd request cycle, then a hit.
    do_load(32'h0000_0100, 1, 32'hDEAD_BEEF, h, d);
    check("cold_was_hit", 32'(h), 32'h0);
    check("cold_rdata", d, 32'hDEAD_BEEF);
    do_load(32'h0000_0100, 0, 32'h0, h, d);
    check("warm_was_hit", 32'(h), 32'h1);
    check("warm_rdata", d, 32'hDEAD_BEEF);

    // Store hit, byte 0 only.
    do_store(32'h0000_0100, 32'h0000_00AA, 4'b0001, 1);
    do_load(32'h0000_0100, 0, 32'h0, h, d);
    check("merge_b0_rdata", d, 32'hDEAD_BEAA);

    // Empty strobe: still written through, line unchanged.
    do_store(32'h0000_0102, 32'h5566_7788, 4'b0000, 0);
    do_load(32'h0000_0100, 0, 32'h0, h, d);
    check("nostrb_rdata", d, 32'hDEAD_BEAA);

    // Sparse strobe with longer memory latency.
    do_store(32'h0000_0100, 32'h1234_5678, 4'b1010, 2);
    do_load(32'h0000_0101, 0, 32'h0, h, d);
    check("merge_b13_rdata", d, 32'h12AD_56AA);

    // Store miss does not allocate.
    do_store(32'h0000_0300, 32'hCAFE_F00D, 4'b1111, 0);
    do_load(32'h0000_0300, 0, 32'h3030_3030, h, d);
    check("nowa_was_hit", 32'(h), 32'h0);

    // Aliasing lines on index 0.
    do_load(32'h0000_0100, 0, 32'h1111_1111, h, d);
    do_load(32'h0000_0200, 1, 32'h2222_2222, h, d);
    do_load(32'h0000_0100, 0, 32'h1111_1111, h, d);
    check("alias_was_hit", 32'(h), 32'h0);
    check("alias_rdata", d, 32'h1111_1111);

    // Top index, back-to-back hits.
    do_load(32'h0000_01FC, 3, 32'hA5A5_0F0F, h, d);
    do_load(32'h0000_01FE, 0, 32'h0, h, d);
    do_load(32'h0000_01FC, 0, 32'h0, h, d);
    check("top_rdata", d, 32'hA5A5_0F0F);
    do_idle(1, 1'b0);

    // 1 miss + 3 hits on a fresh line; store after leaves counters alone.
`ifdef DCACHE_PERF_EN
    h0 = hit_count;
    m0 = miss_count;
`endif
    do_load(32'h0000_0840, 0, 32'h4444_4444, h, d);
    do_load(32'h0000_0840, 0, 32'h0, h, d);
    do_load(32'h0000_0840, 0, 32'h0, h, d);
    do_load(32'h0000_0840, 0, 32'h0, h, d);
    do_store(32'h0000_0840, 32'hFFFF_FFFF, 4'b0100, 0);
    do_idle(1, 1'b0);
`ifdef DCACHE_PERF_EN
    check("perf_hits", hit_count - h0, 32'd3);
    check("perf_misses", miss_count - m0, 32'd1);
`endif
    do_load(32'h0000_0840, 0, 32'h0, h, d);
    check("perf_line_rdata", d, 32'h44FF_4444);

    // Reset while a fill is pending.
    next_cycle();
    core_req   = 1'b1;
    core_write = 1'b0;
    core_addr  = 32'h0000_0204;
    mem_ready  = 1'b0;
    exp_stall  = 1'b1;
    exp_rdata  = 32'h0;
    exp_mem_req = 1'b0;
    exp_chk_wd  = 1'b0;
    pend_misses++;
    @(negedge clk);
    next_cycle();
    exp_mem_req   = 1'b1;
    exp_mem_write = 1'b0;
    exp_mem_addr  = 32'h0000_0204;
    @(negedge clk);
    next_cycle();
    rst       = 1'b1;
    exp_stall = 1'b0;
    exp_rdata = 32'h0;
    @(negedge clk);
    next_cycle();
    rst      = 1'b0;
    core_req = 1'b0;
    set_idle_exp();
    @(negedge clk);
    do_idle(1, 1'b1);

    // Everything filled before the reset now misses.
    do_load(32'h0000_0100, 0, 32'h3333_3333, h, d);
    check("postrst_was_hit", 32'(h), 32'h0);
    check("postrst_rdata", d, 32'h3333_3333);
    do_load(32'h0000_01FC, 1, 32'h0BAD_F00D, h, d);
    check("postrst_top_hit", 32'(h), 32'h0);
    do_load(32'h0000_0100, 0, 32'h0, h, d);
    check("postrst_rehit", d, 32'h3333_3333);
    do_idle(2, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
